// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width and receiver state encoding.
`timescale 1ns/1ps
package spi_pkg;
  localparam int SPI_DATA_W = 12;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_LEAD,
    RX_SHIFT,
    RX_WAIT_CS
  } rx_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses, 1 clk wide,
// arriving one cycle after the synchronized level changes.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_rx.sv
// CS-framed LSB-first SPI receiver; word valid SYNC_STAGES+2 clks after cs rises.
// One-entry holding register: a good frame arriving while full and not drained is dropped with overflow.
`timescale 1ns/1ps
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_EDGES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int LW = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES + 1);

  logic sclk_sync_unused, sclk_rise_unused, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise_unused), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi),
    .sync_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]     lead_cnt_q, lead_cnt_d;
  logic              extra_q, extra_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              armed_q, armed_d;
  logic              start_frame;
  logic              end_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      lead_cnt_q <= '0;
      extra_q    <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      lead_cnt_q <= lead_cnt_d;
      extra_q    <= extra_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    lead_cnt_d  = lead_cnt_q;
    extra_d     = extra_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    ovf_d       = 1'b0;
    start_frame = 1'b0;
    end_frame   = 1'b0;

    // After reset the synchronizers hold a preset cs=1; frames are accepted only
    // once the flushed pipeline has actually shown cs high at the pin.
    settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1;
    armed_d  = armed_q | ((settle_q == SETTLE_MAX) & cs_sync);

    if (valid_q && dout_ready) valid_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (cs_fall && armed_q) start_frame = 1'b1;
      end
      default: begin
        if (cs_rise) begin
          end_frame = 1'b1;
        end else if (cs_fall) begin
          end_frame   = 1'b1;
          start_frame = 1'b1;
        end else if (sclk_fall && !cs_sync) begin
          case (state_q)
            RX_LEAD: begin
              lead_cnt_d = lead_cnt_q + 1'b1;
              if (lead_cnt_q == LW'(LEAD_EDGES - 1)) state_d = RX_SHIFT;
            end
            RX_SHIFT: begin
              shift_d = {mosi_sync, shift_q[DATA_W-1:1]};
              if (bit_cnt_q != CW'(DATA_W)) bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == CW'(DATA_W - 1)) state_d = RX_WAIT_CS;
            end
            RX_WAIT_CS: extra_d = 1'b1;
            default: ;
          endcase
        end
      end
    endcase

    if (end_frame) begin
      state_d = RX_IDLE;
      if (state_q == RX_WAIT_CS && !extra_q) begin
        if (!valid_q || dout_ready) begin
          dout_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end

    if (start_frame) begin
      state_d    = (LEAD_EDGES > 0) ? RX_LEAD : RX_SHIFT;
      shift_d    = '0;
      bit_cnt_d  = '0;
      lead_cnt_d = '0;
      extra_d    = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != RX_IDLE);
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receiver for the 12-bit, LSB-first, CS-framed link driven by our SPI master. It runs entirely in the system clk domain, oversamples sclk/cs/mosi through synchronizers and detects edges. It shifts in one word per CS-low frame and presents it on a valid/ready output with a one-entry holding register. Framing errors and holding-register overflow are flagged.

Parameters:
DATA_W, 12, bits per frame (LSB first)
SYNC_STAGES, 2, synchronizer flops on sclk/cs/mosi (min 2)
LEAD_EDGES, 1, falling sclk edges after CS assertion that are discarded before data

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master (async to clk)
cs  input  1  chip select, active low
mosi  input  1  serial data, changes on sclk rising edge
dout  output  DATA_W  received word, stable while dout_valid=1
dout_valid  output  1  word available
dout_ready  input  1  consumer accepts word when dout_valid&&dout_ready
frame_err  output  1  1-cycle pulse: frame ended with wrong bit count
overflow  output  1  1-cycle pulse: good frame dropped, holding reg full
busy  output  1  1 while state != RX_IDLE

Behaviour:
- Reset (rst=0, async): state RX_IDLE; dout=0, dout_valid=0, frame_err=0, overflow=0, busy=0; shift reg, bit count, lead count=0; synchronizers preset to cs=1, sclk=0, mosi=0. Reset mid-frame discards the partial word; the remainder of that frame is ignored until cs is seen high.
- Sync: all three inputs pass SYNC_STAGES flops; one extra flop on sclk and cs gives edge detects (sclk_fall, cs_fall, cs_rise), each a 1-clk pulse. Input requirement: sclk high and low phases >= SYNC_STAGES+1 clk cycles (master gives 11).
- Sampling: synced mosi captured on sclk_fall only, and only when synced cs=0. Shift right, new bit into MSB, so after DATA_W bits shift_reg[0] = first bit.
- States:
  RX_IDLE: wait cs_fall -> RX_LEAD (LEAD_EDGES>0) or RX_SHIFT; clear counters. sclk edges while cs high are ignored.
  RX_LEAD: count sclk_fall; after LEAD_EDGES edges -> RX_SHIFT.
  RX_SHIFT: each sclk_fall shifts a bit, bit_cnt++; bit_cnt reaching DATA_W -> RX_WAIT_CS.
  RX_WAIT_CS: any further sclk_fall sets sticky extra_edge.
  cs_rise in any non-idle state -> RX_IDLE, and completes the frame: good iff state==RX_WAIT_CS && !extra_edge; otherwise frame_err pulses in the following cycle, no data change.
- Completion (good frame), cycle after cs_rise detect:
  dout_valid=0, or dout_ready=1 in that cycle: dout<=shift_reg, dout_valid<=1.
  dout_valid=1 && dout_ready=0: word dropped, dout unchanged, overflow pulses.
- Handshake: dout_valid falls the cycle after dout_valid&&dout_ready, unless a new word loads the same cycle (valid stays 1, dout updates).
- Latency: cs rising at pin -> dout_valid high after SYNC_STAGES+2 clk cycles.
- cs_fall while not RX_IDLE (glitch): treated as cs_rise+cs_fall, i.e. frame_err then restart. Simultaneous sclk_fall and cs_rise: cs_rise wins, the edge is not sampled.
- Widths: bit_cnt is $clog2(DATA_W+1) bits, saturating; lead count is $clog2(LEAD_EDGES+1) bits.

Decomposition:
- spi_pkg: typedef enum logic [1:0] rx_state_t {RX_IDLE, RX_LEAD, RX_SHIFT, RX_WAIT_CS}; localparam SPI_DATA_W=12 shared with the master.
- Sub-module spi_sync_edge (parameter STAGES, RESET_VAL): synchronizer plus rise/fall pulse outputs. Three instances: sclk, cs, mosi (edge outputs unused for mosi).

Test Plan:
- Master sends 12'hA5C, dout_ready=1 -> dout=12'hA5C, dout_valid 1 cycle, frame_err=overflow=0; 12'h000 and 12'hFFF likewise.
- Two frames 12'h123, 12'h456 with dout_ready=0 -> dout stays 12'h123, overflow pulses once after frame 2; raise ready -> valid drops next cycle.
- cs raised after 7 data bits -> frame_err 1 pulse, dout_valid stays 0, next frame 12'h3C3 received correctly.
- 13 data edges before cs rise -> frame_err pulse, no valid; 12 edges with cs_rise coincident with an extra sclk_fall -> good frame.
- rst=0 for 3 cycles mid-frame (after 5 bits) -> outputs 0 immediately (async), rest of that frame ignored, following frame 12'hABC correct.
- Completion in the same cycle as dout_ready=1 on a held 12'h111 -> dout becomes the new 12'h222, dout_valid stays 1, no overflow.
